// File: rtl/uart_mmio_sched.sv
// ============================================================================
//  Module      : uart_mmio_sched
//  Description : Bus-side scheduler for the UART MMIO peripheral. Polls the
//                status register, drains RX bytes into a one-entry holding
//                register and shares the TX data register between two
//                round-robin byte requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_mmio_sched #(
   parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
   parameter int          POLL_INTERVAL = 0
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_req0_valid,
   input  logic [7:0]  i_req0_data,
   output logic        o_req0_ready,
   input  logic        i_req1_valid,
   input  logic [7:0]  i_req1_data,
   output logic        o_req1_ready,
   output logic        o_rx_valid,
   output logic [7:0]  o_rx_data,
   input  logic        i_rx_ready,
   output logic [31:0] o_mmio_addr,
   output logic [7:0]  o_mmio_data_out,
   input  logic [7:0]  i_mmio_data_in,
   output logic        o_mmio_we,
   output logic        o_mmio_re
);

   localparam logic [31:0] ADDR_RX     = BASE_ADDR;
   localparam logic [31:0] ADDR_TX     = BASE_ADDR + 32'd4;
   localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd8;

   localparam int              CNT_W    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(POLL_INTERVAL);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_POLL   = 3'd0,
      S_RX     = 3'd1,
      S_TX     = 3'd2,
      S_SETTLE = 3'd3,
      S_WAIT   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             grant_q, grant_d;
   logic             rx_valid_q, rx_valid_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Combinational bus controls before reset gating
   logic        mmio_re;
   logic        mmio_we;
   logic [31:0] mmio_addr;
   logic [7:0]  mmio_wdata;
   logic [1:0]  req_ready;

   // State register and datapath registers, synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q    <= S_POLL;
         rr_ptr_q   <= 1'b0;
         grant_q    <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state, bus strobes and holding-register update
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      cnt_d      = cnt_q;
      mmio_re    = 1'b0;
      mmio_we    = 1'b0;
      mmio_addr  = 32'h0000_0000;
      mmio_wdata = 8'h00;
      req_ready  = 2'b00;

      // Consumer pop; an S_RX load below overrides it in the same cycle
      if (rx_valid_q && i_rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         S_POLL: begin
            mmio_re   = 1'b1;
            mmio_addr = ADDR_STATUS;
            if (i_mmio_data_in[0] && !rx_valid_q) begin
               state_d = S_RX;
            end else if (!i_mmio_data_in[1] && (i_req0_valid || i_req1_valid)) begin
               state_d = S_TX;
               grant_d = (i_req0_valid && i_req1_valid) ? rr_ptr_q : i_req1_valid;
            end else if (POLL_INTERVAL != 0) begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         S_RX: begin
            mmio_re    = 1'b1;
            mmio_addr  = ADDR_RX;
            rx_valid_d = 1'b1;
            rx_data_d  = i_mmio_data_in;
            state_d    = S_POLL;
         end
         S_TX: begin
            mmio_we            = 1'b1;
            mmio_addr          = ADDR_TX;
            mmio_wdata         = grant_q ? i_req1_data : i_req0_data;
            req_ready[grant_q] = 1'b1;
            rr_ptr_d           = ~grant_q;
            state_d            = S_SETTLE;
         end
         S_SETTLE: begin
            // Idle slot so tx_busy is visible to the next status read
            state_d = S_POLL;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               state_d = S_POLL;
            end
         end
         default: begin
            state_d = S_POLL;
         end
      endcase
   end

   // Bus outputs are held low while reset is asserted
   assign o_mmio_re       = i_rstn & mmio_re;
   assign o_mmio_we       = i_rstn & mmio_we;
   assign o_mmio_addr     = i_rstn ? mmio_addr : 32'h0000_0000;
   assign o_mmio_data_out = i_rstn ? mmio_wdata : 8'h00;
   assign o_req0_ready    = i_rstn & req_ready[0];
   assign o_req1_ready    = i_rstn & req_ready[1];
   assign o_rx_valid      = rx_valid_q;
   assign o_rx_data       = rx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_sched.sv
// ============================================================================
//  Module      : tb_uart_mmio_sched
//  Description : Self-checking bench for uart_mmio_sched with a small
//                peripheral model and a TX write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_mmio_sched;

   localparam logic [31:0] BASE = 32'h1000_0000;

   typedef struct {
      logic [7:0] data;
      logic [1:0] gnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_v, req1_v, rx_ready;
   logic [7:0]  req0_d, req1_d;
   logic [7:0]  status, rx_byte;

   wire         rdy0, rdy1, rxv, we, re;
   wire  [7:0]  rxd, wdata, din;
   wire  [31:0] addr;

   wire         p_rdy0, p_rdy1, p_rxv, p_we, p_re;
   wire  [7:0]  p_rxd, p_wdata;
   wire  [31:0] p_addr;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   writes   = 0;
   logic prev_we  = 1'b0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   // Peripheral model: combinational read data for status and RX registers
   assign din = re ? ((addr == BASE + 32'd8) ? status : rx_byte) : 8'h00;

   uart_mmio_sched #(.BASE_ADDR(BASE), .POLL_INTERVAL(0)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_req0_valid(req0_v), .i_req0_data(req0_d), .o_req0_ready(rdy0),
      .i_req1_valid(req1_v), .i_req1_data(req1_d), .o_req1_ready(rdy1),
      .o_rx_valid(rxv), .o_rx_data(rxd), .i_rx_ready(rx_ready),
      .o_mmio_addr(addr), .o_mmio_data_out(wdata), .i_mmio_data_in(din),
      .o_mmio_we(we), .o_mmio_re(re)
   );

   uart_mmio_sched #(.BASE_ADDR(BASE), .POLL_INTERVAL(3)) dut_pi (
      .i_clk(clk), .i_rstn(rstn),
      .i_req0_valid(1'b0), .i_req0_data(8'h00), .o_req0_ready(p_rdy0),
      .i_req1_valid(1'b0), .i_req1_data(8'h00), .o_req1_ready(p_rdy1),
      .o_rx_valid(p_rxv), .o_rx_data(p_rxd), .i_rx_ready(1'b0),
      .o_mmio_addr(p_addr), .o_mmio_data_out(p_wdata), .i_mmio_data_in(8'h00),
      .o_mmio_we(p_we), .o_mmio_re(p_re)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_re"},   {31'd0, re}, 32'd0);
      check({tag, "_we"},   {31'd0, we}, 32'd0);
      check({tag, "_addr"}, addr, 32'd0);
      check({tag, "_wd"},   {24'd0, wdata}, 32'd0);
      check({tag, "_rdy"},  {30'd0, rdy1, rdy0}, 32'd0);
      check({tag, "_rxv"},  {31'd0, rxv}, 32'd0);
      check({tag, "_rxd"},  {24'd0, rxd}, 32'd0);
   endtask

   // Write monitor: pops the scoreboard on every TX write and checks spacing
   always @(negedge clk) begin
      check("rw_excl", {31'd0, re & we}, 32'd0);
      if (we) begin
         check("sb_has_exp", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("wr_data",  {24'd0, wdata}, {24'd0, mon_e.data});
            check("wr_addr",  addr, BASE + 32'd4);
            check("wr_grant", {30'd0, rdy1, rdy0}, {30'd0, mon_e.gnt});
         end
         writes++;
      end else begin
         check("rdy_idle", {30'd0, rdy1, rdy0}, 32'd0);
      end
      if (prev_we) begin
         check("settle_idle", {30'd0, we, re}, 32'd0);
      end
      prev_we = we;
   end

   initial begin
      int w0;
      int t[$];
      rstn = 1'b0; req0_v = 1'b0; req1_v = 1'b0; rx_ready = 1'b0;
      req0_d = 8'h00; req1_d = 8'h00; status = 8'h00; rx_byte = 8'h00;

      // Reset state
      repeat (2) cyc();
      check_all_zero("reset");
      rstn = 1'b1;
      #1;

      // Idle polling every cycle
      for (int i = 0; i < 4; i++) begin
         check("idle_re",   {31'd0, re}, 32'd1);
         check("idle_addr", addr, BASE + 32'd8);
         check("idle_rdy",  {30'd0, rdy1, rdy0}, 32'd0);
         check("idle_rxv",  {31'd0, rxv}, 32'd0);
         cyc();
         #1;
      end

      // Single requester 0 byte
      req0_v = 1'b1; req0_d = 8'h41;
      sb.push_back('{8'h41, 2'b01});
      #1;
      check("tx1_poll_re", {31'd0, re}, 32'd1);
      cyc(); #1;
      check("tx1_we",   {31'd0, we}, 32'd1);
      check("tx1_re",   {31'd0, re}, 32'd0);
      check("tx1_addr", addr, BASE + 32'd4);
      check("tx1_data", {24'd0, wdata}, 32'h41);
      check("tx1_rdy",  {30'd0, rdy1, rdy0}, 32'd1);
      cyc();
      req0_v = 1'b0;
      #1;
      check("tx1_settle", {29'd0, we, re, rdy0}, 32'd0);
      cyc(); #1;
      check("tx1_repoll_re",   {31'd0, re}, 32'd1);
      check("tx1_repoll_addr", addr, BASE + 32'd8);

      // Both valid with rr_ptr=1, reset hits during S_TX
      req0_v = 1'b1; req0_d = 8'hA0;
      req1_v = 1'b1; req1_d = 8'hB1;
      #1;
      cyc();
      rstn = 1'b0;
      #1;
      check_all_zero("rst_in_tx");
      cyc(); #1;
      check_all_zero("rst_next");

      // Fairness after reset: first grant must be requester 0
      sb.push_back('{8'hA0, 2'b01});
      sb.push_back('{8'hB1, 2'b10});
      sb.push_back('{8'hA0, 2'b01});
      sb.push_back('{8'hB1, 2'b10});
      w0 = writes;
      rstn = 1'b1;
      for (int k = 0; k < 60 && (writes - w0) < 4; k++) begin
         cyc();
      end
      req0_v = 1'b0; req1_v = 1'b0;
      check("fair_count", writes - w0, 32'd4);
      cyc();
      check("sb_drained", sb.size(), 32'd0);

      // RX has priority; no TX while busy
      status = 8'h03; rx_byte = 8'h5A; req0_v = 1'b1; req0_d = 8'h77;
      #1;
      check("rx_poll_addr", addr, BASE + 32'd8);
      cyc(); #1;
      check("rx_rd_re",   {31'd0, re}, 32'd1);
      check("rx_rd_we",   {31'd0, we}, 32'd0);
      check("rx_rd_addr", addr, BASE);
      cyc();
      status = 8'h02;
      #1;
      check("rx_valid", {31'd0, rxv}, 32'd1);
      check("rx_data",  {24'd0, rxd}, 32'h5A);
      w0 = writes;
      repeat (4) cyc();
      check("busy_no_tx", writes - w0, 32'd0);

      // Holding register full: RX bytes stay in the peripheral
      req0_v = 1'b0; status = 8'h01;
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         check("full_addr", addr, BASE + 32'd8);
         check("full_rxv",  {31'd0, rxv}, 32'd1);
      end
      cyc();
      rx_ready = 1'b1; rx_byte = 8'hC3;
      #1;
      check("pop_rxv_hold", {31'd0, rxv}, 32'd1);
      cyc();
      rx_ready = 1'b0;
      #1;
      check("pop_rxv_clr",  {31'd0, rxv}, 32'd0);
      check("pop_poll",     addr, BASE + 32'd8);
      cyc(); #1;
      check("rx2_rd_re",   {31'd0, re}, 32'd1);
      check("rx2_rd_addr", addr, BASE);
      cyc();
      status = 8'h00;
      #1;
      check("rx2_valid", {31'd0, rxv}, 32'd1);
      check("rx2_data",  {24'd0, rxd}, 32'hC3);

      // POLL_INTERVAL=3 instance: polls four cycles apart
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (p_re) begin
            t.push_back(k);
            check("pi_addr", p_addr, BASE + 32'd8);
         end
      end
      check("pi_count", {31'd0, t.size() >= 4}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         if (i < t.size()) check("pi_gap", t[i] - t[i-1], 32'd4);
      end

      check("sb_final", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
